// File: rtl/alu_sequencer.sv
// Sequences one instruction at a time through an external combinational ALU over a 4-entry register file.
// Optional build macro ALU_SEQ_CARRY_CHAIN_EN: ALU carry-in also ORs in the stored carry flag (multi-word adds).
module alu_sequencer #(
    parameter int DATA_W = 5,
    parameter int SEL_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    input  logic [SEL_W-1:0]  instr_op_i,
    input  logic [1:0]        instr_rd_i,
    input  logic [1:0]        instr_rs1_i,
    input  logic [1:0]        instr_rs2_i,
    input  logic              instr_cin_i,
    input  logic              wr_en_i,
    input  logic [1:0]        wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [1:0]        rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [SEL_W-1:0]  alu_sel_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic              alu_cin_o,
    input  logic [DATA_W-1:0] alu_sum_i,
    input  logic              alu_cout_i,
    output logic              res_valid_o,
    output logic [DATA_W-1:0] res_data_o,
    output logic              res_cout_o,
    output logic              carry_flag_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   rf_q [4];
    logic [DATA_W-1:0]   rf_d [4];
    logic [1:0]          rd_q;
    logic [SEL_W-1:0]    alu_sel_q;
    logic [DATA_W-1:0]   alu_a_q;
    logic [DATA_W-1:0]   alu_b_q;
    logic                alu_cin_q;
    logic                res_valid_q;
    logic [DATA_W-1:0]   res_data_q;
    logic                res_cout_q;
    logic                carry_flag_q;
    logic                cin_sel;

`ifdef ALU_SEQ_CARRY_CHAIN_EN
    assign cin_sel = instr_cin_i | carry_flag_q;
`else
    assign cin_sel = instr_cin_i;
`endif

    // Writeback of the captured result is ordered after the external write so it wins on a collision.
    always_comb begin
        for (int i = 0; i < 4; i++) rf_d[i] = rf_q[i];
        if (wr_en_i) rf_d[wr_addr_i] = wr_data_i;
        if (state_q == CAPTURE) rf_d[rd_q] = res_data_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            for (int i = 0; i < 4; i++) rf_q[i] <= '0;
            rd_q         <= '0;
            alu_sel_q    <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_cin_q    <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_cout_q   <= 1'b0;
            carry_flag_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) rf_q[i] <= rf_d[i];
            res_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (instr_valid_i) begin
                        alu_sel_q <= instr_op_i;
                        alu_a_q   <= rf_q[instr_rs1_i];
                        alu_b_q   <= rf_q[instr_rs2_i];
                        alu_cin_q <= cin_sel;
                        rd_q      <= instr_rd_i;
                        state_q   <= ISSUE;
                    end
                end
                // ALU result is taken at the end of ISSUE so the strobe is visible during CAPTURE.
                ISSUE: begin
                    res_data_q   <= alu_sum_i;
                    res_cout_q   <= alu_cout_i;
                    carry_flag_q <= alu_cout_i;
                    res_valid_q  <= 1'b1;
                    state_q      <= CAPTURE;
                end
                CAPTURE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign instr_ready_o = (state_q == IDLE) && !rst_i;
    assign rd_data_o     = rf_q[rd_addr_i];
    assign alu_sel_o     = alu_sel_q;
    assign alu_a_o       = alu_a_q;
    assign alu_b_o       = alu_b_q;
    assign alu_cin_o     = alu_cin_q;
    // A reset landing in CAPTURE suppresses the strobe for the abandoned instruction.
    assign res_valid_o   = res_valid_q && !rst_i;
    assign res_data_o    = res_data_q;
    assign res_cout_o    = res_cout_q;
    assign carry_flag_o  = carry_flag_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU model attached to the ALU ports.
module tb_alu_sequencer;
    localparam int DW = 5;
    localparam int SW = 4;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_valid, instr_ready, instr_cin;
    logic [SW-1:0] instr_op;
    logic [1:0]    instr_rd, instr_rs1, instr_rs2;
    logic          wr_en;
    logic [1:0]    wr_addr, rd_addr;
    logic [DW-1:0] wr_data, rd_data;
    logic [SW-1:0] alu_sel;
    logic [DW-1:0] alu_a, alu_b, alu_sum, res_data;
    logic          alu_cin, alu_cout, res_valid, res_cout, carry_flag;
    logic [DW:0]   alu_tmp;

    int vectors = 0;
    int miscompares = 0;

    alu_sequencer #(.DATA_W(DW), .SEL_W(SW)) dut (
        .clk_i(clk), .rst_i(rst),
        .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .instr_op_i(instr_op), .instr_rd_i(instr_rd),
        .instr_rs1_i(instr_rs1), .instr_rs2_i(instr_rs2), .instr_cin_i(instr_cin),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .alu_sel_o(alu_sel), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_cin_o(alu_cin),
        .alu_sum_i(alu_sum), .alu_cout_i(alu_cout),
        .res_valid_o(res_valid), .res_data_o(res_data), .res_cout_o(res_cout),
        .carry_flag_o(carry_flag)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_sel)
            4'd1:    alu_tmp = {1'b0, alu_a} + {1'b0, ~alu_b} + {5'd0, alu_cin};
            4'd2:    alu_tmp = {1'b0, alu_a ^ alu_b};
            4'd3:    alu_tmp = {1'b0, alu_a & alu_b};
            default: alu_tmp = {1'b0, alu_a} + {1'b0, alu_b} + {5'd0, alu_cin};
        endcase
    end
    assign alu_sum  = alu_tmp[DW-1:0];
    assign alu_cout = alu_tmp[DW];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Starts at a negedge in IDLE; wr_phase 1 writes during ISSUE, 2 during CAPTURE.
    task automatic run_instr(input string tag, input logic [3:0] op, input logic [1:0] rd,
                             input logic [1:0] rs1, input logic [1:0] rs2, input logic cin,
                             input logic [DW-1:0] exp_data, input logic exp_cout, input logic exp_alu_cin,
                             input int wr_phase, input logic [1:0] wa, input logic [DW-1:0] wd,
                             input logic [DW-1:0] exp_rd);
        chk({tag, ".rdy_idle"}, instr_ready, 1);
        instr_valid = 1'b1; instr_op = op; instr_rd = rd;
        instr_rs1 = rs1; instr_rs2 = rs2; instr_cin = cin;
        @(negedge clk);
        instr_valid = 1'b0;
        if (wr_phase == 1) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; end
        chk({tag, ".rdy_issue"}, instr_ready, 0);
        chk({tag, ".rv_issue"}, res_valid, 0);
        chk({tag, ".alu_cin"}, alu_cin, exp_alu_cin);
        @(negedge clk);
        wr_en = 1'b0;
        if (wr_phase == 2) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; end
        chk({tag, ".rv_cap"}, res_valid, 1);
        chk({tag, ".data"}, res_data, exp_data);
        chk({tag, ".cout"}, res_cout, exp_cout);
        @(negedge clk);
        wr_en = 1'b0;
        rd_addr = rd; #1;
        chk({tag, ".rv_after"}, res_valid, 0);
        chk({tag, ".rd"}, rd_data, exp_rd);
        chk({tag, ".carry"}, carry_flag, exp_cout);
        chk({tag, ".hold"}, res_data, exp_data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_rd = '0;
        instr_rs1 = '0; instr_rs2 = '0; instr_cin = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        repeat (2) @(negedge clk);
        chk("rst.rdy", instr_ready, 0);
        chk("rst.rv", res_valid, 0);
        chk("rst.alu_a", alu_a, 0);
        chk("rst.alu_sel", alu_sel, 0);
        chk("rst.carry", carry_flag, 0);
        chk("rst.rd0", rd_data, 0);
        rst = 1'b0; #1;
        chk("rst.rdy_after", instr_ready, 1);
        @(negedge clk);

        // Basic add
        write_reg(2'd0, 5'd5);
        write_reg(2'd1, 5'd3);
        run_instr("add8", 4'd0, 2'd2, 2'd0, 2'd1, 1'b0, 5'd8, 1'b0, 1'b0, 0, 2'd0, 5'd0, 5'd8);

        // Wrap and carry chaining: 31+31 = 62 -> 30 (cout 1); with chained cin 63 -> 31
        write_reg(2'd0, 5'd31);
        write_reg(2'd1, 5'd1);
        run_instr("addwrap", 4'd0, 2'd2, 2'd0, 2'd1, 1'b0, 5'd0, 1'b1, 1'b0, 0, 2'd0, 5'd0, 5'd0);
        run_instr("chain", 4'd0, 2'd3, 2'd0, 2'd0, 1'b0, CHAIN ? 5'd31 : 5'd30, 1'b1, CHAIN,
                  0, 2'd0, 5'd0, CHAIN ? 5'd31 : 5'd30);

        // Logic ops and the add fallback for an unlisted op code
        write_reg(2'd0, 5'b10110);
        write_reg(2'd1, 5'b01100);
        run_instr("xor", 4'd2, 2'd2, 2'd0, 2'd1, 1'b0, 5'b11010, 1'b0, CHAIN, 0, 2'd0, 5'd0, 5'b11010);
        run_instr("and", 4'd3, 2'd2, 2'd0, 2'd1, 1'b0, 5'b00100, 1'b0, 1'b0, 0, 2'd0, 5'd0, 5'b00100);
        run_instr("opF", 4'hF, 2'd2, 2'd0, 2'd1, 1'b0, 5'b00010, 1'b1, 1'b0, 0, 2'd0, 5'd0, 5'b00010);

        // Back-to-back offers: ready 1,0,0 and a strobe in every third cycle
        instr_valid = 1'b1; instr_op = 4'd2; instr_rd = 2'd3;
        instr_rs1 = 2'd0; instr_rs2 = 2'd1; instr_cin = 1'b0;
        begin
            int nres = 0;
            for (int i = 0; i < 9; i++) begin
                chk("stream.rdy", instr_ready, (i % 3 == 0) ? 1 : 0);
                chk("stream.rv", res_valid, (i % 3 == 2) ? 1 : 0);
                if (res_valid) nres++;
                if (i == 8) instr_valid = 1'b0;
                @(negedge clk);
            end
            chk("stream.count", nres, 3);
        end

        // Writeback beats a same-cycle external write; operands were latched before an ISSUE write
        run_instr("wbwin", 4'd0, 2'd2, 2'd0, 2'd1, 1'b0, 5'd2, 1'b1, 1'b0, 2, 2'd2, 5'd7, 5'd2);
        run_instr("oldrs1", 4'd2, 2'd3, 2'd0, 2'd1, 1'b0, 5'b11010, 1'b0, CHAIN, 1, 2'd0, 5'd0, 5'b11010);
        rd_addr = 2'd0; #1;
        chk("oldrs1.r0_written", rd_data, 0);

        // Reset during ISSUE abandons the instruction
        write_reg(2'd0, 5'd9);
        write_reg(2'd1, 5'd4);
        instr_valid = 1'b1; instr_op = 4'd0; instr_rd = 2'd2;
        instr_rs1 = 2'd0; instr_rs2 = 2'd1; instr_cin = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("rstiss.in_issue", instr_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rstiss.rv", res_valid, 0);
        chk("rstiss.rdy_rst", instr_ready, 0);
        rst = 1'b0; #1;
        chk("rstiss.rdy", instr_ready, 1);
        rd_addr = 2'd2; #1;
        chk("rstiss.rd", rd_data, 0);
        chk("rstiss.carry", carry_flag, 0);
        chk("rstiss.alu_a", alu_a, 0);
        @(negedge clk);
        chk("rstiss.rv_late", res_valid, 0);

        // Back to normal operation after the abandoned instruction
        write_reg(2'd0, 5'd5);
        write_reg(2'd1, 5'd3);
        run_instr("post", 4'd0, 2'd2, 2'd0, 2'd1, 1'b0, 5'd8, 1'b0, 1'b0, 0, 2'd0, 5'd0, 5'd8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
